edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event scheduler. Each of N_CH inputs has its own edge detector (previous-sample XOR).

---
 rtl/edge_evt_pkg.sv | 20 ++
 rtl/edge_evt_ch.sv | 96 +++++++++
 rtl/edge_event_arbiter.sv | 96 +++++++++
 tb/tb_edge_event_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge-event arbiter.
// Latency: n/a (no logic).
// Backpressure: n/a.
// Optional feature macro: EDGE_SYNC_EN (two-flop input synchronizer).
package edge_evt_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_t;

`ifdef EDGE_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

endpackage

// File: rtl/edge_evt_ch.sv
// Per-channel sampler, edge detector, pending-event latch and sticky overflow flag.
// Latency: sig settles before clock k -> s_q at k -> pend at k+1 (one extra stage with EDGE_SYNC_EN).
// Backpressure: while pend is held and not granted, further edges are dropped and flagged in ovf.
// Ports: clk, rst (async active-low), sig (raw line), mode (edge select), armed (detect enable),
//        grant_i (event taken this cycle), clear (sync ovf clear), pend/pkind (pending event, 1=rise), ovf.
// Macro: EDGE_SYNC_EN selects the two-flop synchronizer in front of the edge detector.
module edge_evt_ch
    import edge_evt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    input  edge_mode_t mode,
    input  logic       armed,
    input  logic       grant_i,
    input  logic       clear,
    output logic       pend,
    output logic       pkind,
    output logic       ovf
);

    logic s_q;
    logic s_d;    // value s_q takes at the next clock
    logic prev;

`ifdef EDGE_SYNC_EN
    logic meta_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            meta_q <= sig;
            s_q    <= meta_q;
        end
    end
    assign s_d = meta_q;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= 1'b0;
        end else begin
            s_q <= sig;
        end
    end
    assign s_d = sig;
`endif

    // Before arming, prev tracks the value s_q is about to take, so a line that is
    // already high when reset releases does not look like a fresh rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b0;
        end else begin
            prev <= armed ? s_q : s_d;
        end
    end

    logic rise;
    logic fall;
    logic hit;
    logic busy;

    assign rise = s_q & ~prev;
    assign fall = ~s_q & prev;
    assign hit  = armed & ((rise & ((mode == MODE_RISE) | (mode == MODE_BOTH))) |
                           (fall & ((mode == MODE_FALL) | (mode == MODE_BOTH))));
    // An edge on a channel whose older event is still waiting has nowhere to go.
    assign busy = pend & ~grant_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= 1'b0;
            pkind <= 1'b0;
        end else if (mode == MODE_OFF) begin
            pend  <= 1'b0;
        end else if (hit && !busy) begin
            pend  <= 1'b1;
            pkind <= rise;
        end else if (grant_i) begin
            pend  <= 1'b0;
        end
    end

    // A new overflow outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (hit && busy) begin
            ovf <= 1'b1;
        end else if (clear) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel edge latches, round-robin grant to one consumer.
// Latency: sig_in before clock k -> ev_valid at k+2 (k+3 with EDGE_SYNC_EN).
// Backpressure: ev_ch/ev_rise held while ev_valid & ~ev_ready; 1 transfer/cycle when ready.
// Ports: clk, rst (async active-low), sig_in[N_CH], edge_mode[2*N_CH] (00 off/01 rise/10 fall/11 both),
//        ev_valid/ev_ready/ev_ch/ev_rise (event port), ovf[N_CH] sticky overflow, ovf_clr.
// Macro: EDGE_SYNC_EN adds a two-flop synchronizer on every sig_in line.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     sig_in,
    input  logic [2*N_CH-1:0]   edge_mode,
    input  logic                ev_ready,
    output logic                ev_valid,
    output logic [CH_W-1:0]     ev_ch,
    output logic                ev_rise,
    output logic [N_CH-1:0]     ovf,
    input  logic                ovf_clr
);

    logic            armed;
    logic [CH_W-1:0] rr_ptr;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pkind;
    logic [N_CH-1:0] grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_evt_ch u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig     (sig_in[i]),
            .mode    (edge_mode_t'(edge_mode[2*i +: 2])),
            .armed   (armed),
            .grant_i (grant[i]),
            .clear   (ovf_clr),
            .pend    (pend[i]),
            .pkind   (pkind[i]),
            .ovf     (ovf[i])
        );
    end

    // Round-robin search starting at rr_ptr, wrapping modulo N_CH.
    logic            found;
    logic [CH_W-1:0] win;
    logic [CH_W-1:0] nxt_ptr;
    logic            load;

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 0; off < N_CH; off++) begin
            idx = (int'(rr_ptr) + off) % N_CH;
            if (!found && pend[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    assign nxt_ptr = (win == CH_W'(N_CH - 1)) ? '0 : win + 1'b1;
    assign load    = ~ev_valid | ev_ready;
    assign grant   = (load && found) ? ({{(N_CH-1){1'b0}}, 1'b1} << win) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            ev_rise  <= 1'b0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (found) begin
                ev_valid <= 1'b1;
                ev_ch    <= win;
                ev_rise  <= pkind[win];
                rr_ptr   <= nxt_ptr;
            end else begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig_in;
    logic [7:0] edge_mode;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_ch;
    logic       ev_rise;
    logic [3:0] ovf;
    logic       ovf_clr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] ch;
        logic       rise;
    } ev_t;
    ev_t sb[$];

    edge_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .edge_mode (edge_mode),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_ch     (ev_ch),
        .ev_rise   (ev_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic rise);
        ev_t e;
        e.ch   = ch;
        e.rise = rise;
        sb.push_back(e);
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    // Every completed transfer must match the oldest expected event.
    always @(negedge clk) begin
        if (rst && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {ev_ch, ev_rise}, 32'hFF);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("sb_ch", ev_ch, e.ch);
                check("sb_rise", ev_rise, e.rise);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        sig_in    = 4'b0001;
        edge_mode = 8'b0000_0001;
        ev_ready  = 1'b1;
        ovf_clr   = 1'b0;

        // ---- 1: reset state, arming, first-event latency
        #12;
        check("rst_valid", ev_valid, 0);
        check("rst_ch", ev_ch, 0);
        check("rst_rise", ev_rise, 0);
        check("rst_ovf", ovf, 0);
        tick(1);
        rst = 1'b1;
        tick(6);
        check("armed", dut.armed, 1);
        check("no_event_held_high", ev_valid, 0);
        sig_in[0] = 1'b0;
        tick(3);
        sig_in[0] = 1'b1;
        push(2'd0, 1'b1);
        @(posedge clk);          // k: s_q
        @(posedge clk);          // k+1: pend
        @(negedge clk);
        check("lat_k1_valid", ev_valid, 0);
        @(posedge clk);          // k+2: ev_valid
        @(negedge clk);
        check("lat_k2_valid", ev_valid, 1);
        check("lat_k2_ch", ev_ch, 0);
        check("lat_k2_rise", ev_rise, 1);
        drain("t1_drain");

        // ---- 2: ch1 both-edge falling event; ch2 off toggling
        edge_mode[3:2] = 2'b00;
        sig_in[1] = 1'b1;
        tick(3);
        edge_mode[3:2] = 2'b11;
        tick(2);
        sig_in[1] = 1'b0;
        push(2'd1, 1'b0);
        edge_mode[5:4] = 2'b00;
        sig_in[2] = 1'b1;
        tick(2);
        sig_in[2] = 1'b0;
        tick(2);
        sig_in[2] = 1'b1;
        tick(2);
        sig_in[2] = 1'b0;
        drain("t2_drain");
        tick(4);
        check("t2_idle", ev_valid, 0);

        // one ch3 event so the pointer wraps back to 0
        edge_mode[7:6] = 2'b01;
        sig_in[3] = 1'b1;
        push(2'd3, 1'b1);
        drain("t2b_drain");
        check("rr_wrap", dut.rr_ptr, 0);

        // ---- 3: simultaneous rising edges, back-to-back grants
        edge_mode = 8'b0101_0101;
        sig_in = 4'b0000;
        tick(4);
        check("t3_no_fall_event", ev_valid, 0);
        sig_in = 4'b1111;
        for (int i = 0; i < 4; i++) push(2'(i), 1'b1);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t3_valid%0d", i), ev_valid, 1);
            check($sformatf("t3_ch%0d", i), ev_ch, i);
        end
        tick(1);
        check("t3_rr_ptr", dut.rr_ptr, 0);
        drain("t3_drain");

        // ---- 4: backpressure, overflow, clear
        ev_ready = 1'b0;
        sig_in[3] = 1'b0;
        tick(3);
        edge_mode[7:6] = 2'b11;
        tick(1);
        sig_in[3] = 1'b1;
        push(2'd3, 1'b1);
        tick(4);
        check("t4_presented", ev_valid, 1);
        sig_in[3] = 1'b0;
        push(2'd3, 1'b0);
        tick(3);
        check("t4_no_ovf_yet", ovf, 4'b0000);
        sig_in[3] = 1'b1;      // dropped
        tick(3);
        check("t4_ovf", ovf, 4'b1000);
        check("t4_hold_valid", ev_valid, 1);
        check("t4_hold_ch", ev_ch, 3);
        check("t4_hold_rise", ev_rise, 1);
        sig_in[3] = 1'b0;      // dropped, overflow again
        tick(1);
        ovf_clr = 1'b1;        // same cycle as the new overflow
        tick(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("t4_set_wins", ovf, 4'b1000);
        tick(1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        check("t4_ovf_clr", ovf, 4'b0000);
        check("t4_still_ch", ev_ch, 3);
        ev_ready = 1'b1;
        drain("t4_drain");

        // ---- 5: async reset with an event presented
        ev_ready = 1'b0;
        sig_in[0] = 1'b0;
        tick(3);
        sig_in[0] = 1'b1;
        tick(5);
        check("t5_pre_valid", ev_valid, 1);
        check("t5_pre_ch", ev_ch, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t5_async_valid", ev_valid, 0);
        check("t5_async_ch", ev_ch, 0);
        check("t5_async_rise", ev_rise, 0);
        check("t5_async_ovf", ovf, 0);
        tick(2);
        rst = 1'b1;
        ev_ready = 1'b1;
        tick(10);
        check("t5_no_stale", ev_valid, 0);
        check("t5_sb_empty", sb.size(), 0);
        sig_in[0] = 1'b0;
        tick(3);
        sig_in[0] = 1'b1;
        push(2'd0, 1'b1);
        drain("t5_fresh_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
